// File: rtl/fir_pkg.sv
// Shared types and width helpers for the FIR sample pacer.
// The optional statistics counters are enabled by FIR_SAMPLE_PACER_STATS_EN.
package fir_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int STATS_W = 16;

    function automatic int phase_w(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with a registered storage array and an occupancy count.
// A word pushed into an empty FIFO becomes visible at dout on the following cycle.
module sync_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        clr,
    input  logic [WIDTH-1:0]            din,
    output logic [WIDTH-1:0]            dout,
    output logic                        empty,
    output logic                        full,
    output logic [level_w(DEPTH)-1:0]   level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = level_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Clear wins over both ports; pointers wrap naturally because DEPTH is a power of two.
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == LW'(DEPTH));
    assign level = count;

endmodule

// File: rtl/fir_sample_pacer.sv
// Paces bursty upstream samples into exactly one hold-stable sample per D-clock frame.
// Define FIR_SAMPLE_PACER_STATS_EN to add saturating underflow/overflow event counters.
module fir_sample_pacer
    import fir_pkg::*;
#(
    parameter int D           = 100,
    parameter int SAMPLE_SIZE = 16,
    parameter int DEPTH       = 16,
    parameter int PRIME       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [SAMPLE_SIZE-1:0]      s_data,
    input  logic                        hold,
    input  logic                        flush,
    input  logic                        clr_flags,
    output logic [SAMPLE_SIZE-1:0]      dout,
    output logic                        valid_out,
    output logic [level_w(DEPTH)-1:0]   level,
    output logic                        underflow,
    output logic                        overflow,
    output state_e                      dbg_state
`ifdef FIR_SAMPLE_PACER_STATS_EN
    ,
    output logic [STATS_W-1:0]          uf_count,
    output logic [STATS_W-1:0]          of_count
`endif
);

    localparam int PW = phase_w(D);
    localparam int LW = level_w(DEPTH);

    // Upstream handshake: a sample transfers on a cycle where s_valid and s_ready are both high.
    logic [PW-1:0]          phase;
    logic                   tick;
    logic                   push;
    logic                   pop;
    logic                   out_upd;
    logic                   uf_set;
    logic                   of_set;
    logic                   primed;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [SAMPLE_SIZE-1:0] fifo_head;
    state_e                 state;
    state_e                 state_nx;

    always_ff @(posedge clk) begin
        if (rst)       phase <= '0;
        else if (tick) phase <= '0;
        else           phase <= phase + PW'(1);
    end

    assign tick    = (phase == PW'(D - 1));
    assign s_ready = !fifo_full && !rst;
    assign push    = s_valid && s_ready;
    assign of_set  = s_valid && !s_ready && !rst;
    assign primed  = (level >= LW'(PRIME));

    sync_fifo #(
        .WIDTH (SAMPLE_SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clr   (flush),
        .din   (s_data),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = ST_IDLE;
        end else if (tick) begin
            case (state)
                ST_IDLE: if (primed && !hold)     state_nx = ST_RUN;
                ST_RUN:  if (!hold && fifo_empty) state_nx = ST_IDLE;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // out_upd marks a tick that rewrites valid_out; pop additionally loads dout.
    always_comb begin
        pop     = 1'b0;
        out_upd = 1'b0;
        uf_set  = 1'b0;
        if (tick) begin
            if (flush) begin
                out_upd = 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        out_upd = 1'b1;
                        pop     = primed && !hold;
                    end
                    ST_RUN: begin
                        if (!hold) begin
                            out_upd = 1'b1;
                            pop     = !fifo_empty;
                            uf_set  = fifo_empty;
                        end
                    end
                    default: out_upd = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout      <= '0;
            valid_out <= 1'b0;
        end else if (out_upd) begin
            valid_out <= pop;
            if (pop) dout <= fifo_head;
        end
    end

    // Sticky flags: a new event beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (uf_set)         underflow <= 1'b1;
            else if (clr_flags) underflow <= 1'b0;
            if (of_set)         overflow  <= 1'b1;
            else if (clr_flags) overflow  <= 1'b0;
        end
    end

    assign dbg_state = state;

`ifdef FIR_SAMPLE_PACER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || clr_flags) begin
            uf_count <= '0;
            of_count <= '0;
        end else begin
            if (uf_set && (uf_count != '1)) uf_count <= uf_count + STATS_W'(1);
            if (of_set && (of_count != '1)) of_count <= of_count + STATS_W'(1);
        end
    end
`endif

endmodule

// File: doc/fir_sample_pacer.md
# fir_sample_pacer

Upstream pacing stage for the polyphase FIR decimator. It accepts bursty input samples over a valid/ready handshake into a small FIFO, then presents exactly one sample per D-clock frame on a hold-stable `dout`/`valid_out` pair, which drives the decimator's `din`/`valid_in`. It primes before starting, detects underflow and overflow attempts, and can be paused while coefficients are loaded.

## Interface
- `D`, 100: frame length in clocks; must equal the decimator's `D`; ≥ 2.
- `SAMPLE_SIZE`, 16: sample width, two's complement.
- `DEPTH`, 16: FIFO depth; power of two, ≥ 2.
- `PRIME`, 4: occupancy required to enter RUN; 1 ≤ `PRIME` ≤ `DEPTH`.

- `clk`  in  1  single clock.
- `rst`  in  1  synchronous reset, active high.
- `s_valid`  in  1  upstream sample valid.
- `s_ready`  out  1  FIFO can accept; combinational `!full && !rst`.
- `s_data`  in  `SAMPLE_SIZE`  upstream sample.
- `hold`  in  1  freeze emission; tie to the decimator's `c_we`.
- `flush`  in  1  synchronous FIFO clear; state returns to IDLE.
- `clr_flags`  in  1  clears the sticky flags.
- `dout`  out  `SAMPLE_SIZE`  sample to the decimator `din`.
- `valid_out`  out  1  sample valid to the decimator `valid_in`.
- `level`  out  `$clog2(DEPTH+1)`  FIFO occupancy.
- `underflow`  out  1  sticky; a RUN tick found the FIFO empty.
- `overflow`  out  1  sticky; `s_valid` was high while `s_ready` was low and `rst` was low.

## Operation
- **Phase counter:** counts 0..D-1 and wraps. It free-runs regardless of `hold` and `flush`. `tick` = (phase == D-1).
- **Push:** occurs when `s_valid && s_ready`. The FIFO is first-word-fall-through, and the head is registered. A push into an empty FIFO becomes poppable on the next cycle, not the same cycle.
- **States:** IDLE and RUN. Reset state is IDLE.
- **IDLE, on tick:**
  - If `level ≥ PRIME` and `!hold`: pop the head to `dout`, set `valid_out`=1, go to RUN.
  - Otherwise: `valid_out`=0 and `dout` holds.
- **RUN, on tick:**
  - If `hold`: `dout` and `valid_out` are unchanged and no pop occurs.
  - Else if the FIFO is non-empty: pop the head to `dout`, set `valid_out`=1.
  - Else: `valid_out`=0, `dout` holds, set `underflow`, go to IDLE (re-prime).
- **Outside tick:** `dout` and `valid_out` never change.
- **Push and pop in the same cycle:** both happen; `level` is unchanged.
- **Full FIFO:** `s_ready`=0. No write occurs and no data is lost inside the block.
- **`flush`:**
  - Takes priority over push and pop in the same cycle.
  - Sets `level`=0 and state to IDLE.
  - `dout` and `valid_out` are unchanged until the next tick, which then emits `valid_out`=0.
- **Sticky flags:** `underflow` and `overflow` are set-dominant over `clr_flags` in the same cycle.

## Timing
- **Reset values:** `dout`=0, `valid_out`=0, `level`=0, `underflow`=0, `overflow`=0, phase=0, state IDLE. `s_ready`=0 while `rst` is high.
- **First tick:** the D-th cycle after `rst` falls (phase D-1). Outputs change on that edge.
- **Output stability:** `dout`/`valid_out` are stable for exactly D cycles between updates. The decimator may therefore sample them at any one edge per frame.
- **Latency:** minimum from push to `dout` is 2 cycles when the FIFO is empty, in RUN, and the push lands 2 or more cycles before the tick. Otherwise the sample appears at the first eligible tick.
- **Reset mid-frame:** phase restarts at 0, the FIFO contents are discarded, and the next tick is D cycles later.

## Configuration
- **Macro:** `FIR_SAMPLE_PACER_STATS_EN`.
- **Defined:** adds two 16-bit saturating counters, each incrementing by 1 per event and cleared by `rst` and `clr_flags`:
  - `uf_count`: increments on each cycle in which `underflow` would be set.
  - `of_count`: increments on each cycle in which `overflow` would be set.
- **Undefined:** neither port nor counter exists. All other behaviour is identical.

## Structure
- **Package `fir_pkg`:**
  - state encoding (IDLE=0, RUN=1);
  - helper constants for phase width `$clog2(D)` and level width `$clog2(DEPTH+1)`.
- **Sub-module `sync_fifo`:** parameters `WIDTH`, `DEPTH`; ports `push`, `pop`, `clr`, `din`, `dout`, `empty`, `full`, `level`.
- **Pacer top:** contains the phase counter, state machine, output register, flags and optional counters.

## Test plan
Bench parameters: D=4, DEPTH=8, PRIME=2.
- **Reset check:** assert `rst` for 3 cycles, then push 0x0011 and 0x0022 back-to-back. Required: 0x0011 on `dout` with `valid_out`=1 after the first tick (cycle 3), 0x0022 at the next tick (cycle 7), then `valid_out`=0 and `underflow`=1 at cycle 11.
- **Overflow:** push 9 samples continuously with no tick eligible. Required: `s_ready` falls at `level`=8 and the 9th attempt sets `overflow`. Drained outputs are 0x0001..0x0008 in order, none lost.
- **Hold:** assert `hold` across 2 ticks in RUN with `level`=3. Required: `dout` unchanged for 12 cycles, `level` stays 3, and popping resumes on the first tick after `hold` falls.
- **Flush:** assert `flush` mid-frame with `level`=5. Required: `level`=0 next cycle, `valid_out`=0 at the following tick, and no emission until 2 new pushes arrive.
- **Same-cycle push and pop:** push on the tick cycle with `level`=1 in RUN. Required: `level` stays 1 and order is preserved.
- **Stats counters (with `FIR_SAMPLE_PACER_STATS_EN`):** 3 underflow events give `uf_count`=3, and `clr_flags` returns it to 0.
